// File: rtl/exec_port.sv
// exec_port: one-lane execution port (ALU, shift, optional iterative multiply) with registered writeback.
// Define EXEC_MUL_EN to build the shift-add multiplier, its MUL state and the one-entry skid buffer.
module exec_port #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  enable_i,
    input  logic                  wb_i,
    input  logic [6:0]            opCode_i,
    input  logic [4:0]            regAddr_i,
    input  logic [DATA_WIDTH-1:0] primOperand_i,
    input  logic [DATA_WIDTH-1:0] secOperand_i,
    input  logic [1:0]            functionType_i,
    output logic                  wb_o,
    output logic [4:0]            wbAddr_o,
    output logic [DATA_WIDTH-1:0] wbVal_o,
    output logic [3:0]            flags_o,
    output logic                  busy_o,
    output logic                  overflow_o,
    output logic                  illegal_o,
    output logic                  dbg_state_o
);
    // Handshake: enable_i is a valid-only strobe with no ready; the port always takes the
    // instruction, parking it in the skid during a multiply or dropping it (overflow_o) if full.

    typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

    typedef struct packed {
        logic                  wb;
        logic [2:0]            op;
        logic [4:0]            addr;
        logic [DATA_WIDTH-1:0] p;
        logic [DATA_WIDTH-1:0] s;
        logic [1:0]            ft;
    } instr_t;

    instr_t                  w_in;
    instr_t                  w_sel;
    logic [DATA_WIDTH-1:0]   w_res;
    logic [DATA_WIDTH:0]     w_sum;
    logic [2*DATA_WIDTH-1:0] w_rot;
    logic [3:0]              w_amt;
    logic [3:0]              w_flags;
    logic                    w_c;
    logic                    w_v;
    logic                    w_wb;
    logic                    w_illegal;
    logic                    w_unused_op;

    logic                    r_wb;
    logic [4:0]              r_wb_addr;
    logic [DATA_WIDTH-1:0]   r_wb_val;
    logic [3:0]              r_flags;
    logic                    r_overflow;
    logic                    r_illegal;

    assign w_in        = '{wb: wb_i, op: opCode_i[2:0], addr: regAddr_i, p: primOperand_i,
                           s: secOperand_i, ft: functionType_i};
    assign w_unused_op = &{1'b0, opCode_i[6:3]};

`ifdef EXEC_MUL_EN
    localparam int CW = $clog2(DATA_WIDTH + 1);

    state_t                r_state;
    instr_t                r_skid;
    logic                  r_skid_vld;
    logic                  r_busy;
    logic [CW-1:0]         r_cnt;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [DATA_WIDTH-1:0] r_mcand;
    logic [DATA_WIDTH-1:0] r_mplier;
    logic                  r_mul_wb;
    logic [4:0]            r_mul_addr;
    logic                  w_start_mul;

    // A parked instruction is older than anything arriving now, so it always goes first.
    assign w_sel       = r_skid_vld ? r_skid : w_in;
    assign busy_o      = r_busy;
    assign dbg_state_o = r_state;
`else
    assign w_sel       = w_in;
    assign busy_o      = 1'b0;
    assign dbg_state_o = S_IDLE;
`endif

    always_comb begin
        w_res     = '0;
        w_sum     = '0;
        w_c       = 1'b0;
        w_v       = 1'b0;
        w_wb      = 1'b0;
        w_illegal = 1'b0;
        w_flags   = r_flags;
        w_amt     = w_sel.s[3:0];
        w_rot     = {w_sel.p, w_sel.p} << w_amt;
`ifdef EXEC_MUL_EN
        w_start_mul = 1'b0;
`endif
        case (w_sel.ft)
            2'b00: begin
                w_wb = w_sel.wb;
                case (w_sel.op)
                    3'b000: begin
                        w_sum = {1'b0, w_sel.p} + {1'b0, w_sel.s};
                        w_res = w_sum[DATA_WIDTH-1:0];
                        w_c   = w_sum[DATA_WIDTH];
                        w_v   = (w_sel.p[DATA_WIDTH-1] == w_sel.s[DATA_WIDTH-1]) &&
                                (w_res[DATA_WIDTH-1] != w_sel.p[DATA_WIDTH-1]);
                    end
                    3'b001, 3'b111: begin
                        // Carry out of P + ~S + 1 is the no-borrow flag.
                        w_sum = {1'b0, w_sel.p} + {1'b0, ~w_sel.s} + {{DATA_WIDTH{1'b0}}, 1'b1};
                        w_res = w_sum[DATA_WIDTH-1:0];
                        w_c   = w_sum[DATA_WIDTH];
                        w_v   = (w_sel.p[DATA_WIDTH-1] != w_sel.s[DATA_WIDTH-1]) &&
                                (w_res[DATA_WIDTH-1] != w_sel.p[DATA_WIDTH-1]);
                    end
                    3'b010:  w_res = w_sel.p & w_sel.s;
                    3'b011:  w_res = w_sel.p | w_sel.s;
                    3'b100:  w_res = w_sel.p ^ w_sel.s;
                    3'b101:  w_res = ~w_sel.p;
                    default: w_res = w_sel.s;
                endcase
                if (w_sel.op == 3'b111) begin
                    w_wb = 1'b0;
                end
                w_flags = {w_res[DATA_WIDTH-1], (w_res == '0), w_c, w_v};
            end
            2'b01: begin
                w_wb = w_sel.wb;
                case (w_sel.op[1:0])
                    2'b00:   w_res = w_sel.p << w_amt;
                    2'b01:   w_res = w_sel.p >> w_amt;
                    2'b10:   w_res = $signed(w_sel.p) >>> w_amt;
                    default: w_res = w_rot[2*DATA_WIDTH-1:DATA_WIDTH];
                endcase
            end
`ifdef EXEC_MUL_EN
            2'b10:   w_start_mul = 1'b1;
`endif
            default: w_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_wb       <= 1'b0;
            r_wb_addr  <= '0;
            r_wb_val   <= '0;
            r_flags    <= '0;
            r_overflow <= 1'b0;
            r_illegal  <= 1'b0;
`ifdef EXEC_MUL_EN
            r_state    <= S_IDLE;
            r_skid     <= '0;
            r_skid_vld <= 1'b0;
            r_busy     <= 1'b0;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_mul_wb   <= 1'b0;
            r_mul_addr <= '0;
`endif
        end else begin
            r_wb      <= 1'b0;
            r_illegal <= 1'b0;
`ifdef EXEC_MUL_EN
            case (r_state)
                S_IDLE: begin
                    if (r_skid_vld || enable_i) begin
                        if (r_skid_vld) begin
                            r_skid_vld <= enable_i;
                            r_skid     <= w_in;
                        end
                        if (w_start_mul) begin
                            r_state    <= S_MUL;
                            r_busy     <= 1'b1;
                            r_cnt      <= '0;
                            r_acc      <= '0;
                            r_mcand    <= w_sel.p;
                            r_mplier   <= w_sel.s;
                            r_mul_wb   <= w_sel.wb;
                            r_mul_addr <= w_sel.addr;
                        end else begin
                            r_wb      <= w_wb;
                            r_illegal <= w_illegal;
                            r_flags   <= w_flags;
                            if (w_wb) begin
                                r_wb_addr <= w_sel.addr;
                                r_wb_val  <= w_res;
                            end
                        end
                    end
                end
                default: begin
                    if (enable_i) begin
                        if (!r_skid_vld) begin
                            r_skid_vld <= 1'b1;
                            r_skid     <= w_in;
                        end else begin
                            r_overflow <= 1'b1;
                        end
                    end
                    if (r_cnt == CW'(DATA_WIDTH)) begin
                        r_state   <= S_IDLE;
                        r_busy    <= 1'b0;
                        r_wb      <= r_mul_wb;
                        r_wb_addr <= r_mul_addr;
                        r_wb_val  <= r_acc;
                    end else begin
                        if (r_mplier[0]) begin
                            r_acc <= r_acc + r_mcand;
                        end
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_cnt    <= r_cnt + CW'(1);
                    end
                end
            endcase
`else
            if (enable_i) begin
                r_wb      <= w_wb;
                r_illegal <= w_illegal;
                r_flags   <= w_flags;
                if (w_wb) begin
                    r_wb_addr <= w_sel.addr;
                    r_wb_val  <= w_res;
                end
            end
`endif
        end
    end

    assign wb_o       = r_wb;
    assign wbAddr_o   = r_wb_addr;
    assign wbVal_o    = r_wb_val;
    assign flags_o    = r_flags;
    assign overflow_o = r_overflow;
    assign illegal_o  = r_illegal;

endmodule

// File: tb/tb_exec_port.sv
// Bench for exec_port: directed scenarios plus a random ALU/shift stream against an arithmetic model.
// Multiply scenarios are compiled in only when EXEC_MUL_EN is defined, matching the design build.
module tb_exec_port;
    localparam int DW = 16;

    logic          clock_i = 1'b0;
    logic          reset_i, enable_i, wb_i;
    logic [6:0]    opCode_i;
    logic [4:0]    regAddr_i;
    logic [DW-1:0] primOperand_i, secOperand_i;
    logic [1:0]    functionType_i;
    logic          wb_o, busy_o, overflow_o, illegal_o, dbg_state_o;
    logic [4:0]    wbAddr_o;
    logic [DW-1:0] wbVal_o;
    logic [3:0]    flags_o;

    int            checks = 0;
    int            errors = 0;
    logic [3:0]    m_flags;
    logic [DW+4:0] exp_q[$];

    always #5 clock_i = ~clock_i;

    exec_port #(.DATA_WIDTH(DW)) dut (
        .clock_i(clock_i), .reset_i(reset_i), .enable_i(enable_i), .wb_i(wb_i),
        .opCode_i(opCode_i), .regAddr_i(regAddr_i), .primOperand_i(primOperand_i),
        .secOperand_i(secOperand_i), .functionType_i(functionType_i), .wb_o(wb_o),
        .wbAddr_o(wbAddr_o), .wbVal_o(wbVal_o), .flags_o(flags_o), .busy_o(busy_o),
        .overflow_o(overflow_o), .illegal_o(illegal_o), .dbg_state_o(dbg_state_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic drive(input logic en, input logic wb, input logic [1:0] ft, input logic [6:0] op,
                         input logic [4:0] addr, input logic [DW-1:0] p, input logic [DW-1:0] s);
        enable_i = en; wb_i = wb; functionType_i = ft; opCode_i = op;
        regAddr_i = addr; primOperand_i = p; secOperand_i = s;
    endtask

    task automatic idle();
        drive(1'b0, 1'($urandom), 2'($urandom), 7'($urandom), 5'($urandom), 16'($urandom), 16'($urandom));
    endtask

    task automatic do_reset();
        idle();
        reset_i = 1'b1;
        tick();
        tick();
        reset_i = 1'b0;
        m_flags = 4'h0;
        check("rst_wb", wb_o, 0);
        check("rst_addr", wbAddr_o, 0);
        check("rst_val", wbVal_o, 0);
        check("rst_flags", flags_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_ovf", overflow_o, 0);
        check("rst_ill", illegal_o, 0);
    endtask

    // Reference: plain integer arithmetic on the operation rules; flags carried in m_flags.
    task automatic ref_exec(input logic [1:0] ft, input logic [6:0] op, input logic [DW-1:0] p,
                            input logic [DW-1:0] s, input logic wbr,
                            output logic [DW-1:0] res, output logic wb, output logic ill);
        int a, b, sa, sb, r, sr, amt;
        logic c, v;
        a = p; b = s; sa = $signed(p); sb = $signed(s);
        r = 0; c = 0; v = 0; wb = 0; ill = 0;
        amt = b % 16;
        if (ft == 2'b00) begin
            case (op[2:0])
                3'd0: begin r = a + b; sr = sa + sb; c = (r > 65535); v = (sr > 32767) || (sr < -32768); end
                3'd1, 3'd7: begin r = a - b; sr = sa - sb; c = (a >= b); v = (sr > 32767) || (sr < -32768); end
                3'd2: r = a & b;
                3'd3: r = a | b;
                3'd4: r = a ^ b;
                3'd5: r = ~a;
                default: r = b;
            endcase
            res = r[DW-1:0];
            wb = wbr && (op[2:0] != 3'd7);
            m_flags = {res[DW-1], res == 0, c, v};
        end else if (ft == 2'b01) begin
            case (op[1:0])
                2'd0: r = a << amt;
                2'd1: r = a >> amt;
                2'd2: r = sa >>> amt;
                default: r = (amt == 0) ? a : ((a << amt) | (a >> (16 - amt)));
            endcase
            res = r[DW-1:0];
            wb = wbr;
        end else begin
            res = 0;
            ill = 1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] e_res, p, s;
        logic          e_wb, e_ill;
        logic [1:0]    ft;
        logic [6:0]    op;
        logic [4:0]    addr;
        logic [DW+4:0] ent;
        logic          w;

        reset_i = 1'b1;
        idle();
        do_reset();

        // Signed overflow on ADD; upper opcode bits must be ignored.
        drive(1, 1, 2'b00, 7'h78, 5'd3, 16'h7FFF, 16'h0001);
        tick();
        check("add_wb", wb_o, 1);
        check("add_addr", wbAddr_o, 3);
        check("add_val", wbVal_o, 16'h8000);
        check("add_flags", flags_o, 4'b1001);
        drive(1, 1, 2'b00, 7'h07, 5'd4, 16'd5, 16'd5);
        tick();
        check("cmp_wb", wb_o, 0);
        check("cmp_flags", flags_o, 4'b0110);
        drive(1, 1, 2'b01, 7'h00, 5'd9, 16'h0001, 16'd4);
        tick();
        check("shl_wb", wb_o, 1);
        check("shl_val", wbVal_o, 16'h0010);
        check("shl_flags", flags_o, 4'b0110);
        idle();
        tick();
        check("strobe_len", wb_o, 0);
        drive(1, 1, 2'b11, 7'h00, 5'd2, 16'h1234, 16'h0001);
        tick();
        check("t11_ill", illegal_o, 1);
        check("t11_wb", wb_o, 0);
        idle();
        tick();
        check("t11_pulse", illegal_o, 0);

`ifndef EXEC_MUL_EN
        drive(1, 1, 2'b10, 7'h00, 5'd2, 16'h0003, 16'h0005);
        tick();
        check("nomul_ill", illegal_o, 1);
        check("nomul_wb", wb_o, 0);
        check("nomul_busy", busy_o, 0);
        idle();
        tick();
        check("nomul_pulse", illegal_o, 0);
        check("nomul_busy2", busy_o, 0);
`else
        do_reset();
        drive(1, 1, 2'b10, 7'h00, 5'd7, 16'h0123, 16'h0010);
        tick();
        idle();
        for (int k = 1; k <= DW; k++) begin
            tick();
            check($sformatf("mul_busy_%0d", k), busy_o, 1);
            check($sformatf("mul_nowb_%0d", k), wb_o, 0);
        end
        tick();
        check("mul_wb", wb_o, 1);
        check("mul_val", wbVal_o, 16'h1230);
        check("mul_addr", wbAddr_o, 7);
        check("mul_busy_end", busy_o, 0);
        tick();
        check("mul_strobe_len", wb_o, 0);

        // Skid fill, drop with sticky overflow, then skid drains with a capture behind it.
        do_reset();
        drive(1, 1, 2'b10, 7'h00, 5'd1, 16'd3, 16'd5);
        tick();
        drive(1, 1, 2'b00, 7'h00, 5'd4, 16'h0010, 16'h0020);
        tick();
        drive(1, 1, 2'b00, 7'h01, 5'd5, 16'd9, 16'd1);
        tick();
        check("skid_ovf", overflow_o, 1);
        idle();
        for (int k = 3; k <= DW; k++) tick();
        tick();
        check("skid_mul_wb", wb_o, 1);
        check("skid_mul_val", wbVal_o, 15);
        drive(1, 1, 2'b00, 7'h03, 5'd6, 16'h00F0, 16'h000F);
        tick();
        check("skid_exec_wb", wb_o, 1);
        check("skid_exec_addr", wbAddr_o, 4);
        check("skid_exec_val", wbVal_o, 16'h0030);
        check("skid_exec_flags", flags_o, 4'b0000);
        idle();
        tick();
        check("skid_cap_wb", wb_o, 1);
        check("skid_cap_addr", wbAddr_o, 6);
        check("skid_cap_val", wbVal_o, 16'h00FF);
        tick();
        check("skid_drained", wb_o, 0);
        check("ovf_sticky", overflow_o, 1);

        // Reset at edge 8 of a multiply, with an ALU op parked in the skid.
        do_reset();
        drive(1, 1, 2'b10, 7'h00, 5'd1, 16'hFFFF, 16'hFFFF);
        tick();
        drive(1, 1, 2'b00, 7'h00, 5'd2, 16'd1, 16'd1);
        tick();
        idle();
        for (int k = 2; k <= 7; k++) tick();
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        check("abort_busy", busy_o, 0);
        check("abort_val", wbVal_o, 0);
        check("abort_ovf", overflow_o, 0);
        w = 0;
        for (int k = 0; k < 24; k++) begin
            tick();
            w = w | wb_o | busy_o;
        end
        check("abort_no_wb", w, 0);

        for (int t = 0; t < 6; t++) begin
            p = 16'($urandom); s = 16'($urandom); addr = 5'($urandom_range(1, 31));
            drive(1, 1, 2'b10, 7'($urandom), addr, p, s);
            tick();
            idle();
            w = 0;
            for (int k = 0; k < 40 && !w; k++) begin
                tick();
                w = wb_o;
            end
            check("rmul_done", w, 1);
            check("rmul_val", wbVal_o, 16'((32'(p) * 32'(s)) & 32'hFFFF));
            check("rmul_addr", wbAddr_o, addr);
            check("rmul_flags", flags_o, m_flags);
            tick();
        end
`endif

        // Random back-to-back stream; scoreboard holds {addr, value} of expected writebacks.
        do_reset();
        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 9) < 8) begin
`ifdef EXEC_MUL_EN
                case ($urandom_range(0, 4))
                    0, 1:    ft = 2'b00;
                    2, 3:    ft = 2'b01;
                    default: ft = 2'b11;
                endcase
`else
                ft = 2'($urandom);
`endif
                op = 7'($urandom); addr = 5'($urandom); w = 1'($urandom_range(0, 5) != 0);
                p = ($urandom_range(0, 3) == 0) ? 16'h7FFF : 16'($urandom);
                s = ($urandom_range(0, 3) == 0) ? p : 16'($urandom);
                drive(1, w, ft, op, addr, p, s);
                ref_exec(ft, op, p, s, w, e_res, e_wb, e_ill);
                if (e_wb) exp_q.push_back({addr, e_res});
            end else begin
                idle();
                e_wb = 0; e_ill = 0;
            end
            tick();
            check("rnd_wb", wb_o, e_wb);
            check("rnd_ill", illegal_o, e_ill);
            check("rnd_flags", flags_o, m_flags);
            if (wb_o) begin
                if (exp_q.size() == 0) begin
                    check("rnd_unexpected_wb", 0, 1);
                end else begin
                    ent = exp_q.pop_front();
                    check("rnd_result", {wbAddr_o, wbVal_o}, ent);
                end
            end
        end
        check("rnd_busy", busy_o, 0);
        check("rnd_ovf", overflow_o, 0);
        check("sb_drain", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
